interval_timer_arbiter: RTL and testbench



---
 rtl/interval_timer_arbiter_pkg.sv | 18 +
 rtl/interval_timer_arbiter_rr_pick.sv | 49 ++++
 rtl/interval_timer_arbiter.sv | 141 ++++++++++++++
 tb/tb_interval_timer_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/interval_timer_arbiter_pkg.sv
// Shared definitions for the interval timer arbiter and its round-robin picker.
// Contents: FSM state encodings, default sizing constants, one-hot helper.
package interval_timer_arbiter_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned CNT_W_DEF = 4;
    localparam int unsigned MAX_REQ   = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One-hot vector with bit idx set; callers truncate to their own width.
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        onehot = MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/interval_timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Ports:
//   req   - request vector
//   ptr   - index where the search starts
//   sel   - index of the chosen request (valid only when valid=1)
//   valid - at least one request is set
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel,
    output logic             valid
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    // Rotate so that bit 0 of w_rot corresponds to requester ptr.
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[N_REQ-1:0];

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        w_off = '0;
        valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

    // Undo the rotation: sel = (ptr + off) mod N_REQ.
    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= N_W) begin
            w_sum = w_sum - N_W;
        end
        sel = w_sum[IDX_W-1:0];
    end

endmodule

// File: rtl/interval_timer_arbiter.sv
// Shares one down-counter among N_REQ requesters, granting in round-robin order.
// Ports:
//   clk, rst - rising-edge clock, asynchronous active-high reset
//   req      - per-requester request, held until done (dropping it aborts)
//   len      - per-requester interval, requester i at [i*CNT_W +: CNT_W]
//   grant    - registered one-hot owner, 0 when idle
//   done     - one-cycle completion pulse to the owner
//   busy     - high while running or signalling done
//   count    - current counter value
module interval_timer_arbiter
    import interval_timer_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [CNT_W-1:0]       count
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [1:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_done;
    logic             r_busy;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_owner;

    logic [1:0]       w_state_nxt;
    logic [N_REQ-1:0] w_grant_nxt;
    logic [N_REQ-1:0] w_done_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_owner_nxt;
    logic [IDX_W-1:0] w_owner_inc;
    logic [IDX_W-1:0] w_sel;
    logic             w_valid;
    logic [CNT_W-1:0] w_len_arr [N_REQ];

    // Unpack the flat interval bus.
    for (genvar g = 0; g < N_REQ; g++) begin : g_len
        assign w_len_arr[g] = len[g*CNT_W +: CNT_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .sel   (w_sel),
        .valid (w_valid)
    );

    // Pointer moves past the owner whenever its turn ends (done or abort).
    assign w_owner_inc = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_count <= w_count_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        w_count_nxt = r_count;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;

        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                w_count_nxt = '0;
                if (w_valid) begin
                    w_state_nxt = ST_RUN;
                    w_grant_nxt = N_REQ'(onehot(32'(w_sel)));
                    w_count_nxt = w_len_arr[w_sel];
                    w_owner_nxt = w_sel;
                end
            end

            ST_RUN: begin
                if (!req[r_owner]) begin
                    // Owner withdrew: release silently.
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_count_nxt = '0;
                    w_ptr_nxt   = w_owner_inc;
                end else if (r_count != '0) begin
                    w_count_nxt = r_count - CNT_W'(1);
                end else begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = r_grant;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_ptr_nxt   = w_owner_inc;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign count = r_count;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Directed bench for interval_timer_arbiter (N_REQ=4, CNT_W=4).
module tb_interval_timer_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    interval_timer_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic b, input logic [3:0] c);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".count"}, 32'(count), 32'(c));
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset holds everything at zero even with all requests up
        rst = 1'b1;
        req = 4'b1111;
        len = 16'h0000;
        #1;
        chk_out("t1_rst_t0", 4'b0000, 4'b0000, 1'b0, 4'd0);
        step();
        chk_out("t1_rst_e1", 4'b0000, 4'b0000, 1'b0, 4'd0);
        step();
        chk_out("t1_rst_e2", 4'b0000, 4'b0000, 1'b0, 4'd0);
        rst = 1'b0;
        step();
        chk_out("t1_first_grant", 4'b0001, 4'b0000, 1'b1, 4'd0);
        req = 4'b0000;
        step();
        chk_out("t1_abort", 4'b0000, 4'b0000, 1'b0, 4'd0);
        // ptr is now 1

        // 2: single requester 2, len=3
        req = 4'b0100;
        len = 16'h0300;
        step();
        chk_out("t2_e0", 4'b0100, 4'b0000, 1'b1, 4'd3);
        step();
        chk_out("t2_e1", 4'b0100, 4'b0000, 1'b1, 4'd2);
        len = 16'hF0F0;  // changes after the grant edge must not matter
        step();
        chk_out("t2_e2", 4'b0100, 4'b0000, 1'b1, 4'd1);
        step();
        chk_out("t2_e3", 4'b0100, 4'b0000, 1'b1, 4'd0);
        step();
        chk_out("t2_e4_done", 4'b0100, 4'b0100, 1'b1, 4'd0);
        req = 4'b0000;
        step();
        chk_out("t2_e5_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);
        // ptr is now 3

        // 4: requester 3 with len=0
        req = 4'b1000;
        len = 16'h0000;
        step();
        chk_out("t4_e0", 4'b1000, 4'b0000, 1'b1, 4'd0);
        step();
        chk_out("t4_e1_done", 4'b1000, 4'b1000, 1'b1, 4'd0);
        req = 4'b0000;
        step();
        chk_out("t4_e2_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);
        // ptr is now 0

        // 3: all requesting, len=1 each: grants rotate 0,1,2,3,0
        req = 4'b1111;
        len = 16'h1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e;
            e = 4'(1 << (k % 4));
            step();
            chk_out($sformatf("t3_g%0d_load", k), e, 4'b0000, 1'b1, 4'd1);
            step();
            chk_out($sformatf("t3_g%0d_zero", k), e, 4'b0000, 1'b1, 4'd0);
            step();
            chk_out($sformatf("t3_g%0d_done", k), e, e, 1'b1, 4'd0);
            if (k == 4) req = 4'b0000;
            step();
            chk_out($sformatf("t3_g%0d_idle", k), 4'b0000, 4'b0000, 1'b0, 4'd0);
        end
        // ptr is now 1

        // 5: requester 1 (len 9) aborts at count=5 with requester 2 waiting
        req = 4'b0110;
        len = 16'h0290;
        step();
        chk_out("t5_e0", 4'b0010, 4'b0000, 1'b1, 4'd9);
        step();
        chk_out("t5_e1", 4'b0010, 4'b0000, 1'b1, 4'd8);
        step();
        chk_out("t5_e2", 4'b0010, 4'b0000, 1'b1, 4'd7);
        step();
        chk_out("t5_e3", 4'b0010, 4'b0000, 1'b1, 4'd6);
        step();
        chk_out("t5_e4", 4'b0010, 4'b0000, 1'b1, 4'd5);
        req = 4'b0100;
        step();
        chk_out("t5_abort", 4'b0000, 4'b0000, 1'b0, 4'd0);
        step();
        chk_out("t5_next", 4'b0100, 4'b0000, 1'b1, 4'd2);
        req = 4'b0000;
        step();
        chk_out("t5_abort2", 4'b0000, 4'b0000, 1'b0, 4'd0);
        // ptr is now 3

        // 6: asynchronous reset mid-run at count=7
        req = 4'b1000;
        len = 16'h9002;
        step();
        chk_out("t6_e0", 4'b1000, 4'b0000, 1'b1, 4'd9);
        step();
        step();
        chk_out("t6_e2", 4'b1000, 4'b0000, 1'b1, 4'd7);
        #3;
        rst = 1'b1;
        #1;
        chk_out("t6_async_rst", 4'b0000, 4'b0000, 1'b0, 4'd0);
        req = 4'b0011;
        step();
        chk_out("t6_rst_held", 4'b0000, 4'b0000, 1'b0, 4'd0);
        rst = 1'b0;
        step();
        chk_out("t6_after_rst", 4'b0001, 4'b0000, 1'b1, 4'd2);
        req = 4'b0000;
        step();
        chk_out("t6_abort", 4'b0000, 4'b0000, 1'b0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
